// File: rtl/irq_timer_pkg.sv
// Shared register map, CTRL bit positions and id encoding for the
// timer/interrupt controller.
package irq_timer_pkg;

    typedef enum logic [2:0] {
        REG_MTIME    = 3'd0,
        REG_MTIMECMP = 3'd1,
        REG_CTRL     = 3'd2,
        REG_EXT_EN   = 3'd3,
        REG_EXT_MODE = 3'd4,
        REG_EXT_PEND = 3'd5,
        REG_CLAIM    = 3'd6,
        REG_RSVD     = 3'd7
    } reg_addr_e;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_AR_BIT = 1;
    localparam int ID_W        = 5;
    localparam int MAX_EXT     = 31;

    // Lowest set bit wins; result is index+1 so that 0 means "nothing pending".
    function automatic logic [ID_W-1:0] first_pending_id(input logic [MAX_EXT-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = MAX_EXT - 1; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i + 1);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_channel.sv
// One external interrupt channel: two-flop synchroniser, rising-edge
// detector and the pending bit in either edge or level mode.
module irq_channel (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    input  logic edge_mode_i,
    input  logic clr_i,
    input  logic flush_i,
    output logic pend_o
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;
    logic rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= irq_i;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

    // A fresh edge beats a clear arriving in the same cycle so it is never lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_o <= 1'b0;
        end else if (flush_i) begin
            pend_o <= 1'b0;
        end else if (edge_mode_i) begin
            if (rise)       pend_o <= 1'b1;
            else if (clr_i) pend_o <= 1'b0;
        end else begin
            pend_o <= sync_p1;
        end
    end

endmodule

// File: rtl/irq_timer_ctrl.sv
// Machine timer plus external interrupt controller behind a small
// word-addressed register bus.
module irq_timer_ctrl
    import irq_timer_pkg::*;
#(
    parameter int DW      = 32,
    parameter int NUM_EXT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               sel_i,
    input  logic               we_i,
    input  logic [2:0]         addr_i,
    input  logic [DW-1:0]      wdata_i,
    output logic [DW-1:0]      rdata_o,
    input  logic [NUM_EXT-1:0] ext_irq_i,
    output logic               t_intr_o,
    output logic               e_intr_o,
    output logic [ID_W-1:0]    irq_id_o
);

    reg_addr_e          addr;
    logic               wr;
    logic               rd;
    logic               claim;
    logic [DW-1:0]      mtime;
    logic [DW-1:0]      mtimecmp;
    logic               timer_en;
    logic               auto_reload;
    logic [NUM_EXT-1:0] ext_en;
    logic [NUM_EXT-1:0] ext_mode;
    logic [NUM_EXT-1:0] ext_pend;
    logic [NUM_EXT-1:0] mode_nxt;
    logic [NUM_EXT-1:0] flush;
    logic [NUM_EXT-1:0] clr;
    logic [NUM_EXT-1:0] active;
    logic [MAX_EXT-1:0] active_ext;
    logic [DW-1:0]      rd_mux;

    assign addr  = reg_addr_e'(addr_i);
    assign wr    = sel_i & we_i;
    assign rd    = sel_i & ~we_i;
    assign claim = rd && (addr == REG_CLAIM);

    assign t_intr_o = timer_en && (mtime >= mtimecmp);

    // Bus write to MTIME overrides both auto-reload and counting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            timer_en    <= 1'b0;
            auto_reload <= 1'b0;
            ext_en      <= '0;
            ext_mode    <= '0;
        end else begin
            if (wr && addr == REG_MTIME)     mtime <= wdata_i;
            else if (auto_reload && t_intr_o) mtime <= '0;
            else if (timer_en)                mtime <= mtime + DW'(1);

            if (wr && addr == REG_MTIMECMP) mtimecmp <= wdata_i;
            if (wr && addr == REG_CTRL) begin
                timer_en    <= wdata_i[CTRL_EN_BIT];
                auto_reload <= wdata_i[CTRL_AR_BIT];
            end
            if (wr && addr == REG_EXT_EN) ext_en <= wdata_i[NUM_EXT-1:0];
            ext_mode <= mode_nxt;
        end
    end

    // Channels see the new mode in the write cycle so edge->level follows at once.
    assign mode_nxt = (wr && addr == REG_EXT_MODE) ? wdata_i[NUM_EXT-1:0] : ext_mode;
    assign flush    = mode_nxt & ~ext_mode;

    for (genvar i = 0; i < NUM_EXT; i++) begin : g_ch
        assign clr[i] = (wr && addr == REG_EXT_PEND && wdata_i[i])
                      | (claim && irq_id_o == ID_W'(i + 1));

        irq_channel u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .irq_i       (ext_irq_i[i]),
            .edge_mode_i (mode_nxt[i]),
            .clr_i       (clr[i]),
            .flush_i     (flush[i]),
            .pend_o      (ext_pend[i])
        );
    end

    assign active = ext_pend & ext_en;

    always_comb begin
        active_ext = '0;
        active_ext[NUM_EXT-1:0] = active;
    end

    assign irq_id_o = first_pending_id(active_ext);

    always_ff @(posedge clk_i) begin
        if (rst_i) e_intr_o <= 1'b0;
        else       e_intr_o <= |active;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_MTIME:    rd_mux = mtime;
            REG_MTIMECMP: rd_mux = mtimecmp;
            REG_CTRL: begin
                rd_mux[CTRL_EN_BIT] = timer_en;
                rd_mux[CTRL_AR_BIT] = auto_reload;
            end
            REG_EXT_EN:   rd_mux[NUM_EXT-1:0] = ext_en;
            REG_EXT_MODE: rd_mux[NUM_EXT-1:0] = ext_mode;
            REG_EXT_PEND: rd_mux[NUM_EXT-1:0] = ext_pend;
            REG_CLAIM:    rd_mux[ID_W-1:0]    = irq_id_o;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)   rdata_o <= '0;
        else if (rd) rdata_o <= rd_mux;
    end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl with a queue-based scoreboard.
module tb_irq_timer_ctrl;
    import irq_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic [3:0]  ext = 4'd0;
    logic        t_intr;
    logic        e_intr;
    logic [4:0]  irq_id;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t rq[$];
    exp_t sq[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic rd_seen = 1'b0;

    irq_timer_ctrl #(.DW(32), .NUM_EXT(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .sel_i     (sel),
        .we_i      (we),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata),
        .ext_irq_i (ext),
        .t_intr_o  (t_intr),
        .e_intr_o  (e_intr),
        .irq_id_o  (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Monitor: rdata is valid the cycle after a read strobe; probes are popped each negedge.
    always @(posedge clk) rd_seen <= sel & ~we;

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        if (rd_seen) begin
            if (rq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: got %h expected nothing queued", rdata);
            end else begin
                e = rq.pop_front();
                check(e.name, rdata, e.exp);
            end
        end
        while (sq.size() > 0) begin
            e = sq.pop_front();
            case (e.kind)
                1:       act = {31'd0, t_intr};
                2:       act = {31'd0, e_intr};
                default: act = {27'd0, irq_id};
            endcase
            check(e.name, act, e.exp);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick(1);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string n);
        exp_t e;
        e.kind = 0; e.exp = exp; e.name = n;
        rq.push_back(e);
        sel = 1'b1; we = 1'b0; addr = a;
        tick(1);
        sel = 1'b0;
    endtask

    task automatic probe(input int kind, input logic [31:0] exp, input string n);
        exp_t e;
        e.kind = kind; e.exp = exp; e.name = n;
        sq.push_back(e);
    endtask

    task automatic probe_quiet(input string n);
        probe(1, 0, {n, "_t_intr"});
        probe(2, 0, {n, "_e_intr"});
        probe(3, 0, {n, "_irq_id"});
    endtask

    task automatic read_reset_values(input string n);
        rd(REG_MTIME,    32'h0,        {n, "_mtime"});
        rd(REG_MTIMECMP, 32'hFFFFFFFF, {n, "_mtimecmp"});
        rd(REG_CTRL,     32'h0,        {n, "_ctrl"});
        rd(REG_EXT_EN,   32'h0,        {n, "_ext_en"});
        rd(REG_EXT_MODE, 32'h0,        {n, "_ext_mode"});
        rd(REG_EXT_PEND, 32'h0,        {n, "_ext_pend"});
        rd(REG_CLAIM,    32'h0,        {n, "_claim"});
        rd(REG_RSVD,     32'h0,        {n, "_rsvd"});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, queued rd=%0d probes=%0d", rq.size(), sq.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        tick(1);
        probe_quiet("in_reset");
        tick(2);
        rst = 1'b0;
        tick(1);
        probe_quiet("after_reset");
        read_reset_values("por");

        // One-shot compare: match 10 cycles after enable, stays high.
        wr(REG_MTIMECMP, 32'd10);
        wr(REG_CTRL, 32'd1);
        probe(1, 0, "oneshot_start");
        tick(9);
        probe(1, 0, "oneshot_cyc9");
        tick(1);
        probe(1, 1, "oneshot_cyc10");
        tick(3);
        probe(1, 1, "oneshot_hold");
        rd(REG_MTIME, 32'd13, "oneshot_mtime");
        wr(REG_CTRL, 32'd0);

        // Wrap at all-ones.
        wr(REG_MTIME, 32'hFFFFFFFE);
        wr(REG_MTIMECMP, 32'hFFFFFFFF);
        wr(REG_CTRL, 32'd1);
        probe(1, 0, "wrap_before");
        tick(1);
        probe(1, 1, "wrap_match");
        tick(1);
        probe(1, 0, "wrap_dropped");
        rd(REG_MTIME, 32'd0, "wrap_mtime");
        wr(REG_CTRL, 32'd0);

        // Auto-reload with period 4.
        wr(REG_MTIME, 32'd0);
        wr(REG_MTIMECMP, 32'd3);
        wr(REG_CTRL, 32'd3);
        probe(1, 0, "ar_m0");
        tick(2);
        probe(1, 0, "ar_m2");
        tick(1);
        probe(1, 1, "ar_m3");
        tick(1);
        probe(1, 0, "ar_reload");
        tick(3);
        probe(1, 1, "ar_m3_again");
        tick(1);
        probe(1, 0, "ar_reload_again");
        rd(REG_MTIME, 32'd0, "ar_read0");
        rd(REG_MTIME, 32'd1, "ar_read1");
        rd(REG_MTIME, 32'd2, "ar_read2");
        rd(REG_MTIME, 32'd3, "ar_read3");
        rd(REG_MTIME, 32'd0, "ar_read4");
        wr(REG_CTRL, 32'd0);
        rd(REG_CTRL, 32'd0, "ctrl_off");

        // Edge channels and claim priority.
        wr(REG_EXT_EN, 32'hF);
        wr(REG_EXT_MODE, 32'hF);
        rd(REG_EXT_MODE, 32'hF, "mode_readback");
        ext = 4'b0100;
        tick(1);
        ext = 4'b0000;
        tick(2);
        ext = 4'b0010;
        tick(1);
        ext = 4'b0000;
        tick(5);
        rd(REG_EXT_PEND, 32'h6, "edge_pend");
        probe(2, 1, "edge_e_intr");
        probe(3, 2, "edge_irq_id");
        rd(REG_CLAIM, 32'd2, "claim_first");
        rd(REG_CLAIM, 32'd3, "claim_second");
        rd(REG_CLAIM, 32'd0, "claim_empty");
        probe(2, 0, "edge_e_intr_low");
        probe(3, 0, "edge_irq_id_low");

        // Write-1-to-clear and reserved offset.
        ext = 4'b1000;
        tick(1);
        ext = 4'b0000;
        tick(4);
        rd(REG_EXT_PEND, 32'h8, "w1c_set");
        wr(REG_EXT_PEND, 32'h8);
        rd(REG_EXT_PEND, 32'h0, "w1c_cleared");
        wr(REG_RSVD, 32'hDEADBEEF);
        rd(REG_RSVD, 32'h0, "rsvd_read");

        // Level channel 0.
        wr(REG_EXT_MODE, 32'hE);
        ext = 4'b0001;
        tick(4);
        rd(REG_CLAIM, 32'd1, "level_claim1");
        rd(REG_CLAIM, 32'd1, "level_claim2");
        wr(REG_EXT_PEND, 32'h1);
        rd(REG_EXT_PEND, 32'h1, "level_w1c_ignored");
        ext = 4'b0000;
        tick(2);
        probe(3, 1, "level_still_pending");
        tick(1);
        probe(3, 0, "level_dropped");

        // Reset with live timer and pending interrupts.
        wr(REG_EXT_MODE, 32'hF);
        ext = 4'b0101;
        tick(1);
        ext = 4'b0000;
        tick(4);
        rd(REG_EXT_PEND, 32'h5, "pre_rst_pend");
        probe(3, 1, "pre_rst_irq_id");
        probe(2, 1, "pre_rst_e_intr");
        wr(REG_MTIME, 32'd50);
        wr(REG_CTRL, 32'd1);
        tick(3);
        rst = 1'b1;
        tick(1);
        probe_quiet("mid_reset");
        tick(1);
        rst = 1'b0;
        tick(1);
        probe_quiet("post_reset");
        read_reset_values("rst2");
        tick(3);
        probe_quiet("post_reset_idle");

        tick(3);
        if (rq.size() != 0 || sq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d reads and %0d probes unchecked, expected 0", rq.size(), sq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_timer_ctrl.md
IRQ_TIMER_CTRL -- requirements
Module: irq_timer_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data/timer width.
REQ-002 SHALL have parameter NUM_EXT, default 4, range 1..31, meaning external interrupt channel count.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports sel_i/we_i (input, 1), addr_i (input, 3, word offset), wdata_i (input, DW), rdata_o (output, DW): register bus.
REQ-006 SHALL have port ext_irq_i, input, NUM_EXT, meaning asynchronous external interrupt lines.
REQ-007 SHALL have ports t_intr_o and e_intr_o, output, 1, meaning timer and external requests to the core's t_intr/e_intr.
REQ-008 SHALL have port irq_id_o, output, 5, meaning highest-priority pending channel id+1, 0 if none.

Function
REQ-009 SHALL decode registers: 0 MTIME, 1 MTIMECMP, 2 CTRL (bit0 timer_en, bit1 auto_reload), 3 EXT_EN, 4 EXT_MODE (1=edge, 0=level), 5 EXT_PEND, 6 CLAIM; offset 7 reads 0, writes ignored.
REQ-010 SHALL perform writes when sel_i&we_i at the clock edge; rdata_o SHALL be registered, valid one cycle after sel_i&~we_i, else hold its last value.
REQ-011 SHALL synchronise ext_irq_i through two flops per channel; edge detection SHALL use the synchronised value and its previous value (rising edge only).
REQ-012 SHALL increment MTIME by 1 per cycle while timer_en=1, wrap modulo 2^DW from all-ones to 0, and hold while timer_en=0.
REQ-013 SHALL give a bus write to MTIME priority over increment and reload in the same cycle.
REQ-014 SHALL assert t_intr_o combinationally when timer_en=1 and MTIME >= MTIMECMP (unsigned).
REQ-015 SHALL, when auto_reload=1 and match holds, load MTIME with 0 on the next edge (t_intr_o one-cycle pulse per period MTIMECMP+1).
REQ-016 SHALL, for edge channels, set EXT_PEND[i] on a synchronised rising edge; writing 1 to bit i SHALL clear it; set SHALL win over a simultaneous clear.
REQ-017 SHALL, for level channels, make EXT_PEND[i] track the synchronised level; writes have no effect.
REQ-018 SHALL drive e_intr_o = |(EXT_PEND & EXT_EN), registered (one cycle after EXT_PEND updates).
REQ-019 SHALL compute irq_id_o as lowest-index enabled pending channel +1 (channel 0 highest priority), 0 if none.
REQ-020 SHALL, on CLAIM read, return irq_id_o and clear that channel's pending bit if edge mode; a same-cycle new edge on that channel SHALL keep it pending.
REQ-021 SHALL ignore bits of EXT_EN/EXT_MODE/EXT_PEND at or above NUM_EXT (read 0).
REQ-022 SHALL, for a mode change edge->level, immediately follow the level; level->edge SHALL clear the bit.

Reset
REQ-023 SHALL on rst_i set MTIME=0, MTIMECMP=all-ones, CTRL=0, EXT_EN=0, EXT_MODE=0, EXT_PEND=0, sync flops=0, rdata_o=0.
REQ-024 SHALL hold t_intr_o=0, e_intr_o=0, irq_id_o=0 during and the cycle after reset.
REQ-025 SHALL let reset asserted mid-count or with pending interrupts abort all state; first edge after release shall not register a spurious rising edge.

Structure
REQ-026 SHALL place register offsets, CTRL bit positions and the id width in a shared package irq_timer_pkg.
REQ-027 SHALL implement per-channel sync/edge/pending logic in one sub-module irq_channel, instantiated NUM_EXT times.
REQ-028 SHALL stay within 120-400 lines of RTL total, no latches, no multi-clock logic.

Verification
REQ-029 SHALL check: MTIMECMP=10, CTRL=1 -> t_intr_o rises exactly 10 cycles after enable write and stays high.
REQ-030 SHALL check: MTIMECMP=3, CTRL=3 -> t_intr_o pulses one cycle every 4 cycles, MTIME reads 0..3 cycling.
REQ-031 SHALL check: MTIME written 0xFFFFFFFE, MTIMECMP=0xFFFFFFFF -> match after 1 cycle, MTIME wraps to 0, t_intr_o drops.
REQ-032 SHALL check: EXT_EN=0xF, MODE=0xF, pulse ext_irq_i[2] then [1] -> e_intr_o high, CLAIM returns 2 then 3 then 0, e_intr_o low.
REQ-033 SHALL check: level channel 0 held high -> CLAIM returns 1 repeatedly, pending clears only after input drops (3-cycle latency).
REQ-034 SHALL check: rst_i asserted with MTIME=50 and EXT_PEND=0x5 -> all registers read reset values, no interrupt output after release.
